// File: rtl/ext_pkg.sv
// Opcode encoding and legality helper for the immediate extender.
package ext_pkg;

  typedef logic [2:0] ext_op_t;

  localparam ext_op_t EXT_ZERO      = 3'b000;
  localparam ext_op_t EXT_SIGNED    = 3'b001;
  localparam ext_op_t EXT_HIGHPOS   = 3'b010;
  localparam ext_op_t EXT_SIGN_SHL2 = 3'b011;
  localparam ext_op_t EXT_ZERO_SHL2 = 3'b100;

  function automatic logic is_legal_op(input ext_op_t op);
    return op <= EXT_ZERO_SHL2;
  endfunction

endpackage

// File: rtl/ext_core.sv
// Combinational immediate extension: raw immediate + opcode -> extended value and illegal flag.
module ext_core
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32
) (
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_op,
  output logic [OUT_W-1:0] data,
  output logic             err
);

  logic [OUT_W-1:0] zext;
  logic [OUT_W-1:0] sext;

  assign zext = OUT_W'(in_data);
  assign sext = OUT_W'($signed(in_data));

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    data = '0;
    err  = 1'b0;
    case (in_op)
      EXT_ZERO:      data = zext;
      EXT_SIGNED:    data = sext;
      // Shift by zero degenerates to in_data when OUT_W == IN_W.
      EXT_HIGHPOS:   data = zext << (OUT_W - IN_W);
      EXT_SIGN_SHL2: data = sext << 2;
      EXT_ZERO_SHL2: data = zext << 2;
      default:       err  = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: handshake in, extend, queue in a small FIFO, count illegal ops.
module imm_ext_pipe
  import ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [2:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  generate
    if (OUT_W < IN_W) begin : g_bad_width
      $error("imm_ext_pipe: OUT_W must be >= IN_W");
    end
    if (IN_W < 2) begin : g_bad_in_w
      $error("imm_ext_pipe: IN_W must be >= 2");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("imm_ext_pipe: DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [OUT_W-1:0] ext_data;
  logic             ext_err;

  ext_core #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_core (
    .in_data (in_data),
    .in_op   (in_op),
    .data    (ext_data),
    .err     (ext_err)
  );

  logic [OUT_W-1:0] mem_data [DEPTH];
  logic             mem_err  [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // Handshake depends only on registered count, so out_ready never reaches in_ready.
  assign in_ready  = (count < CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_data  = mem_data[rd_ptr];
  assign out_err   = mem_err[rd_ptr];

  // NOTE: storage is reset on purpose: out_data/out_err must read 0 straight out of reset,
  // and with only DEPTH entries the extra reset fan-out is negligible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
        mem_err[i]  <= 1'b0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      err_cnt <= '0;
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= ext_data;
        mem_err[wr_ptr]  <= ext_err;
        wr_ptr           <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Only an accepted illegal op counts; a stalled one is seen once, when it finally pushes.
      if (push && !is_legal_op(in_op) && (err_cnt != '1)) begin
        err_cnt <= err_cnt + ERR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe against a queue-based arithmetic reference model.
module tb_imm_ext_pipe;

  localparam int IN_W  = 16;
  localparam int OUT_W = 32;
  localparam int DEPTH = 2;
  localparam int ERR_W = 8;
  localparam longint ERR_MAX = (longint'(1) << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [2:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;
  logic [ERR_W-1:0] err_cnt;

  imm_ext_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .DEPTH (DEPTH),
    .ERR_W (ERR_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic             err;
  } entry_t;

  entry_t exp_q[$];
  longint exp_err_cnt = 0;
  int     n_checks = 0;
  int     n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Reference: interpret the immediate as a number and apply the opcode arithmetically.
  function automatic entry_t model_ext(input logic [IN_W-1:0] d, input logic [2:0] op);
    entry_t r;
    longint u = longint'(d);
    longint s = d[IN_W-1] ? u - (longint'(1) << IN_W) : u;
    longint v;
    r.err = 1'b0;
    case (op)
      3'd0:    v = u;
      3'd1:    v = s;
      3'd2:    v = u * (longint'(1) << (OUT_W - IN_W));
      3'd3:    v = s * 4;
      3'd4:    v = u * 4;
      default: begin v = 0; r.err = 1'b1; end
    endcase
    r.data = OUT_W'(v);
    return r;
  endfunction

  // Called at a falling edge: drive inputs, compare outputs with the model, advance one cycle.
  task automatic tick(input logic v, input logic [IN_W-1:0] d, input logic [2:0] op, input logic rdy);
    bit do_push;
    bit do_pop;
    entry_t e;
    in_valid  = v;
    in_data   = d;
    in_op     = op;
    out_ready = rdy;
    check("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() > 0));
    check("err_cnt", 64'(err_cnt), 64'(exp_err_cnt));
    if (exp_q.size() > 0) begin
      check("out_data", 64'(out_data), 64'(exp_q[0].data));
      check("out_err", 64'(out_err), 64'(exp_q[0].err));
    end
    do_pop  = (exp_q.size() > 0) && rdy;
    do_push = v && (exp_q.size() < DEPTH);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      e = model_ext(d, op);
      exp_q.push_back(e);
      if (e.err && exp_err_cnt < ERR_MAX) exp_err_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) tick(1'b0, '0, 3'd0, 1'b1);
  endtask

  logic [IN_W-1:0] rd;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_op = '0; out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_err", 64'(out_err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // All legal ops on 0x8001, consumer always ready.
    for (int op = 0; op < 5; op++) tick(1'b1, 16'h8001, 3'(op), 1'b1);
    drain();

    // Backpressure: two pushes fill, third is refused until space appears.
    tick(1'b1, 16'h0001, 3'd1, 1'b0);
    tick(1'b1, 16'h7FFF, 3'd1, 1'b0);
    tick(1'b1, 16'h1234, 3'd0, 1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    tick(1'b1, 16'h1234, 3'd0, 1'b1);
    tick(1'b1, 16'h1234, 3'd0, 1'b1);
    drain();

    // Continuous streaming at count=1 across pointer wrap.
    tick(1'b1, 16'(($urandom)), 3'($urandom_range(0, 4)), 1'b1);
    for (int i = 0; i < 8; i++) begin
      tick(1'b1, 16'($urandom), 3'($urandom_range(0, 4)), 1'b1);
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    drain();

    // Single illegal op, then saturation of the error counter.
    tick(1'b1, 16'hABCD, 3'b110, 1'b1);
    tick(1'b0, '0, 3'd0, 1'b1);
    check("illegal_err_cnt", 64'(err_cnt), 64'd1);
    for (int i = 0; i < 300; i++) tick(1'b1, 16'($urandom), 3'($urandom_range(5, 7)), 1'b1);
    drain();
    check("sat_err_cnt", 64'(err_cnt), 64'(ERR_MAX));

    // Async reset between edges with two entries queued.
    tick(1'b1, 16'h1111, 3'd0, 1'b0);
    tick(1'b1, 16'h2222, 3'd0, 1'b0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_out_valid", 64'(out_valid), 64'd0);
    check("async_in_ready", 64'(in_ready), 64'd1);
    check("async_err_cnt", 64'(err_cnt), 64'd0);
    exp_q.delete();
    exp_err_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Stalled illegal op held while full, accepted exactly once.
    tick(1'b1, 16'h0042, 3'd4, 1'b0);
    tick(1'b1, 16'h0043, 3'd3, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b1, 16'h5555, 3'b111, 1'b0);
    tick(1'b1, 16'h5555, 3'b111, 1'b1);
    tick(1'b1, 16'h5555, 3'b111, 1'b0);
    tick(1'b0, '0, 3'd0, 1'b0);
    check("stall_err_cnt", 64'(err_cnt), 64'd1);
    drain();

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      rd = 16'($urandom);
      tick(1'($urandom), rd, 3'($urandom_range(0, 7)), 1'($urandom));
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
